// File: rtl/router_pkg.sv
// Router flit and PC word definitions shared by the serializer,
// the router and the deserializer.
package router_pkg;

    localparam int NPCcode  = 8;
    localparam int NPCdata  = 24;
    localparam int NPCroute = 10;
    localparam int FLIT_W   = NPCroute + 1;
    localparam int NPAY     = NPCcode + NPCdata;
    localparam int NFLITS   = (NPAY + NPCroute - 1) / NPCroute;
    localparam int ACC_W    = NFLITS * NPCroute;
    localparam int CNT_W    = $clog2(NFLITS);
    localparam int WORD_W   = NPCroute + NPAY;

    typedef struct packed {
        logic [NPCroute-1:0] payload;
        logic                tail;
    } flit_t;

    typedef struct packed {
        logic [NPCroute-1:0] route;
        logic [NPCcode-1:0]  code;
        logic [NPCdata-1:0]  data;
    } pc_word_t;

    typedef enum logic {
        HEAD,
        BODY
    } state_t;

endpackage

// File: rtl/bz_deserializer.sv
// Router exit stage: pops header/data flits from the router FIFO and
// rebuilds {route, code, data} words on a valid/ack channel.
module bz_deserializer
    import router_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] data_in,
    input  logic        empty,
    output logic        rdreq,
    output logic [41:0] PC_out_channel_d,
    output logic        PC_out_channel_v,
    input  logic        PC_out_channel_a,
    output logic        err,
    output logic [7:0]  err_count
);

    flit_t               flit;
    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [NPCroute-1:0] route;
    logic                last;
    logic                head_pop;
    logic                body_pop;
    logic                load;
    logic                bad;
    pc_word_t            word;

    assign flit     = flit_t'(data_in);
    assign last     = (cnt == CNT_W'(NFLITS - 1));
    assign acc_next = {acc[ACC_W-NPCroute-1:0], flit.payload};
    assign head_pop = (state == HEAD) && rdreq;
    assign body_pop = (state == BODY) && rdreq;
    assign load     = body_pop && last;
    // header-only worm, or a tail before the word is complete
    assign bad      = (head_pop || (body_pop && !last)) && flit.tail;

    assign word.route = route;
    assign word.code  = acc_next[NPAY-1:NPCdata];
    assign word.data  = acc_next[NPCdata-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= HEAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rdreq      = 1'b0;
        unique case (state)
            HEAD: begin
                rdreq = !empty;
                if (rdreq && !flit.tail) state_next = BODY;
            end
            BODY: begin
                rdreq = !empty && (!PC_out_channel_v || PC_out_channel_a);
                if (rdreq && flit.tail) state_next = HEAD;
            end
            default: state_next = HEAD;
        endcase
        if (reset) begin
            rdreq      = 1'b0;
            state_next = HEAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            route            <= '0;
            acc              <= '0;
            cnt              <= '0;
            PC_out_channel_v <= 1'b0;
            PC_out_channel_d <= '0;
            err              <= 1'b0;
            err_count        <= '0;
        end else begin
            err <= bad;
            if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (head_pop) route <= flit.payload;
            if (body_pop) begin
                acc <= acc_next;
                if (last || flit.tail) cnt <= '0;
                else                   cnt <= cnt + CNT_W'(1);
            end
            // a fresh word on the ack edge keeps v high
            if (load) begin
                PC_out_channel_d <= word;
                PC_out_channel_v <= 1'b1;
            end else if (PC_out_channel_a) begin
                PC_out_channel_v <= 1'b0;
            end
        end
    end

endmodule
